// File: rtl/countdown_bcd_timer.sv
// -----------------------------------------------------------------------------
// countdown_bcd_timer
//   MM:SS BCD round timer for the 123-wooden-man game. Feeds the 4-digit
//   seven-segment driver directly with display codes (0-9 digits, D dash,
//   E blank).
//
// Parameters
//   TICK_DIV  : clk cycles per one-second tick (>= 2)
//   START_MIN : initial minutes (0..99)
//   START_SEC : initial seconds (0..59)
//
// Ports
//   clk     : system clock
//   rst     : synchronous active-high reset
//   start   : pulse, begin / resume / restart
//   pause   : level, freezes the count while high in RUN
//   clear   : pulse, abort to IDLE
//   nums    : {M1,M0,S1,S0} display codes, [15:12] leftmost
//   running : high only in RUN
//   expired : one-cycle pulse when the count reaches 00:00
// -----------------------------------------------------------------------------
module countdown_bcd_timer #(
    parameter int TICK_DIV  = 100000000,
    parameter int START_MIN = 1,
    parameter int START_SEC = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    output logic [15:0] nums,
    output logic        running,
    output logic        expired
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [3:0] ST_M1 = 4'(START_MIN / 10);
    localparam logic [3:0] ST_M0 = 4'(START_MIN % 10);
    localparam logic [3:0] ST_S1 = 4'(START_SEC / 10);
    localparam logic [3:0] ST_S0 = 4'(START_SEC % 10);
    localparam logic START_ZERO = (START_MIN == 0) && (START_SEC == 0);

    localparam logic [3:0] CODE_DASH  = 4'hD;
    localparam logic [3:0] CODE_BLANK = 4'hE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [3:0]    m1, m0, s1, s0;
    logic [PW-1:0] presc;
    logic          blink;

    // Time value one second earlier, with BCD borrow chain.
    logic [3:0] m1_n, m0_n, s1_n, s0_n;
    logic       dec_zero;

    always_comb begin
        m1_n = m1;
        m0_n = m0;
        s1_n = s1;
        s0_n = s0;
        if (s0 != 4'd0) begin
            s0_n = s0 - 4'd1;
        end else begin
            s0_n = 4'd9;
            if (s1 != 4'd0) begin
                s1_n = s1 - 4'd1;
            end else begin
                s1_n = 4'd5;
                if (m0 != 4'd0) begin
                    m0_n = m0 - 4'd1;
                end else begin
                    m0_n = 4'd9;
                    // 00:00 never reaches a decrement, so m1 is nonzero here
                    if (m1 != 4'd0) m1_n = m1 - 4'd1;
                end
            end
        end
        dec_zero = (m1_n == 4'd0) && (m0_n == 4'd0) &&
                   (s1_n == 4'd0) && (s0_n == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            m1      <= ST_M1;
            m0      <= ST_M0;
            s1      <= ST_S1;
            s0      <= ST_S0;
            presc   <= '0;
            blink   <= 1'b0;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (clear) begin
                state <= IDLE;
                m1    <= ST_M1;
                m0    <= ST_M0;
                s1    <= ST_S1;
                s0    <= ST_S0;
                presc <= '0;
                blink <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            m1    <= ST_M1;
                            m0    <= ST_M0;
                            s1    <= ST_S1;
                            s0    <= ST_S0;
                            presc <= '0;
                            blink <= 1'b0;
                            if (START_ZERO) begin
                                state   <= DONE;
                                expired <= 1'b1;
                            end else begin
                                state <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        // pause beats a coinciding tick: nothing advances
                        if (pause) begin
                            state <= PAUSE;
                        end else if (presc == PRESC_MAX) begin
                            presc <= '0;
                            m1    <= m1_n;
                            m0    <= m0_n;
                            s1    <= s1_n;
                            s0    <= s0_n;
                            if (dec_zero) begin
                                state   <= DONE;
                                expired <= 1'b1;
                                blink   <= 1'b0;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    PAUSE: begin
                        // prescaler is left untouched so the partial second survives
                        if (start && !pause) state <= RUN;
                    end
                    DONE: begin
                        if (start) begin
                            state <= RUN;
                            m1    <= ST_M1;
                            m0    <= ST_M0;
                            s1    <= ST_S1;
                            s0    <= ST_S0;
                            presc <= '0;
                            blink <= 1'b0;
                        end else if (presc == PRESC_MAX) begin
                            presc <= '0;
                            blink <= ~blink;
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        case (state)
            IDLE:        nums = {4{CODE_DASH}};
            RUN, PAUSE:  nums = {m1, m0, s1, s0};
            DONE:        nums = blink ? {4{CODE_BLANK}} : 16'h0000;
            default:     nums = {4{CODE_DASH}};
        endcase
    end

    assign running = (state == RUN);

endmodule

// File: tb/tb_countdown_bcd_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_bcd_timer
//   Directed bench. Several timer instances with different start values share
//   one set of control inputs; each scenario resets them all and then checks
//   the instance it is about. TICK_DIV=4 everywhere.
// -----------------------------------------------------------------------------
module tb_countdown_bcd_timer;

    logic clk = 1'b0;
    logic rst, start, pause, clear;

    logic [15:0] nums_a, nums_b, nums_c, nums_d, nums_e, nums_f;
    logic        run_a, run_b, run_c, run_d, run_e, run_f;
    logic        exp_a, exp_b, exp_c, exp_d, exp_e, exp_f;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    countdown_bcd_timer #(.TICK_DIV(4), .START_MIN(0),  .START_SEC(3))  u_a (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
        .nums(nums_a), .running(run_a), .expired(exp_a));
    countdown_bcd_timer #(.TICK_DIV(4), .START_MIN(1),  .START_SEC(0))  u_b (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
        .nums(nums_b), .running(run_b), .expired(exp_b));
    countdown_bcd_timer #(.TICK_DIV(4), .START_MIN(10), .START_SEC(0))  u_c (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
        .nums(nums_c), .running(run_c), .expired(exp_c));
    countdown_bcd_timer #(.TICK_DIV(4), .START_MIN(0),  .START_SEC(5))  u_d (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
        .nums(nums_d), .running(run_d), .expired(exp_d));
    countdown_bcd_timer #(.TICK_DIV(4), .START_MIN(0),  .START_SEC(0))  u_e (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
        .nums(nums_e), .running(run_e), .expired(exp_e));
    countdown_bcd_timer #(.TICK_DIV(4), .START_MIN(0),  .START_SEC(45)) u_f (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
        .nums(nums_f), .running(run_f), .expired(exp_f));

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pause = 1'b0; clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = i[0];
            step();
            vectors++;
            if (nums_a !== 16'hDDDD) begin
                miscompares++;
                $display("FAIL reset_nums cyc%0d got %h want DDDD", i, nums_a);
            end
            vectors++;
            if (run_a !== 1'b0 || exp_a !== 1'b0 || exp_e !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_flags cyc%0d got run=%b exp=%b exp_e=%b want 0", i, run_a, exp_a, exp_e);
            end
        end
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_countdown();
        logic [15:0] want;
        do_reset();
        pulse_start();
        vectors++;
        if (nums_a !== 16'h0003 || run_a !== 1'b1) begin
            miscompares++;
            $display("FAIL cd_entry got %h run=%b want 0003 run=1", nums_a, run_a);
        end
        for (int c = 1; c <= 11; c++) begin
            step();
            want = (c < 4) ? 16'h0003 : (c < 8) ? 16'h0002 : 16'h0001;
            vectors++;
            if (nums_a !== want || exp_a !== 1'b0) begin
                miscompares++;
                $display("FAIL cd_count c=%0d got %h exp=%b want %h exp=0", c, nums_a, exp_a, want);
            end
        end
        step();  // cycle 12: reaches 00:00
        vectors++;
        if (nums_a !== 16'h0000 || exp_a !== 1'b1 || run_a !== 1'b0) begin
            miscompares++;
            $display("FAIL cd_expire got %h exp=%b run=%b want 0000 exp=1 run=0", nums_a, exp_a, run_a);
        end
        for (int c = 13; c <= 23; c++) begin
            step();
            want = ((((c - 12) / 4) % 2) == 1) ? 16'hEEEE : 16'h0000;
            vectors++;
            if (nums_a !== want || exp_a !== 1'b0 || run_a !== 1'b0) begin
                miscompares++;
                $display("FAIL cd_blink c=%0d got %h exp=%b run=%b want %h exp=0 run=0", c, nums_a, exp_a, run_a, want);
            end
        end
    endtask

    task automatic test_restart();
        // u_a is in DONE from the previous scenario
        pulse_start();
        vectors++;
        if (nums_a !== 16'h0003 || run_a !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_entry got %h run=%b want 0003 run=1", nums_a, run_a);
        end
        for (int c = 0; c < 4; c++) step();
        vectors++;
        if (nums_a !== 16'h0002) begin
            miscompares++;
            $display("FAIL restart_tick got %h want 0002", nums_a);
        end
    endtask

    task automatic test_borrow();
        do_reset();
        pulse_start();
        vectors++;
        if (nums_b !== 16'h0100 || nums_c !== 16'h1000) begin
            miscompares++;
            $display("FAIL borrow_entry got %h %h want 0100 1000", nums_b, nums_c);
        end
        for (int c = 0; c < 4; c++) step();
        vectors++;
        if (nums_b !== 16'h0059) begin
            miscompares++;
            $display("FAIL borrow_0100 got %h want 0059", nums_b);
        end
        vectors++;
        if (nums_c !== 16'h0959) begin
            miscompares++;
            $display("FAIL borrow_1000 got %h want 0959", nums_c);
        end
        for (int c = 0; c < 4; c++) step();
        vectors++;
        if (nums_c !== 16'h0958 || nums_b !== 16'h0058) begin
            miscompares++;
            $display("FAIL borrow_second got %h %h want 0958 0058", nums_c, nums_b);
        end
    endtask

    task automatic test_pause();
        do_reset();
        pulse_start();
        step();
        step();  // prescaler now at 2
        pause = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            vectors++;
            if (nums_d !== 16'h0005 || run_d !== 1'b0) begin
                miscompares++;
                $display("FAIL pause_hold c=%0d got %h run=%b want 0005 run=0", c, nums_d, run_d);
            end
        end
        pause = 1'b0;
        pulse_start();
        vectors++;
        if (nums_d !== 16'h0005 || run_d !== 1'b1) begin
            miscompares++;
            $display("FAIL pause_resume got %h run=%b want 0005 run=1", nums_d, run_d);
        end
        step();
        vectors++;
        if (nums_d !== 16'h0005) begin
            miscompares++;
            $display("FAIL pause_partial1 got %h want 0005", nums_d);
        end
        step();
        vectors++;
        if (nums_d !== 16'h0004) begin
            miscompares++;
            $display("FAIL pause_partial2 got %h want 0004", nums_d);
        end
        pause = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        vectors++;
        if (run_d !== 1'b0 || nums_d !== 16'h0004) begin
            miscompares++;
            $display("FAIL pause_start_both got %h run=%b want 0004 run=0", nums_d, run_d);
        end
        for (int c = 0; c < 5; c++) step();
        vectors++;
        if (run_d !== 1'b0 || nums_d !== 16'h0004) begin
            miscompares++;
            $display("FAIL pause_frozen got %h run=%b want 0004 run=0", nums_d, run_d);
        end
        pause = 1'b0;
    endtask

    task automatic test_clear();
        do_reset();
        pulse_start();
        for (int c = 0; c < 12; c++) step();
        vectors++;
        if (nums_f !== 16'h0042 || run_f !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_pre got %h run=%b want 0042 run=1", nums_f, run_f);
        end
        vectors++;
        if (run_a !== 1'b0 || nums_a !== 16'h0000) begin
            miscompares++;
            $display("FAIL clr_done_pre got %h run=%b want 0000 run=0", nums_a, run_a);
        end
        clear = 1'b1; start = 1'b1;
        step();
        clear = 1'b0; start = 1'b0;
        vectors++;
        if (nums_f !== 16'hDDDD || run_f !== 1'b0 || exp_f !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_start got %h run=%b exp=%b want DDDD run=0 exp=0", nums_f, run_f, exp_f);
        end
        vectors++;
        if (nums_a !== 16'hDDDD) begin
            miscompares++;
            $display("FAIL clr_in_done got %h want DDDD", nums_a);
        end
        step();
        vectors++;
        if (nums_f !== 16'hDDDD || exp_f !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_stays got %h exp=%b want DDDD exp=0", nums_f, exp_f);
        end
        pulse_start();
        for (int c = 0; c < 5; c++) step();
        vectors++;
        if (nums_f !== 16'h0044) begin
            miscompares++;
            $display("FAIL rst_pre got %h want 0044", nums_f);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (nums_f !== 16'hDDDD || run_f !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_midrun got %h run=%b want DDDD run=0", nums_f, run_f);
        end
    endtask

    task automatic test_zero_start();
        do_reset();
        vectors++;
        if (nums_e !== 16'hDDDD) begin
            miscompares++;
            $display("FAIL zero_idle got %h want DDDD", nums_e);
        end
        pulse_start();
        vectors++;
        if (nums_e !== 16'h0000 || exp_e !== 1'b1 || run_e !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_start got %h exp=%b run=%b want 0000 exp=1 run=0", nums_e, exp_e, run_e);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if (nums_e !== 16'h0000 || exp_e !== 1'b0 || run_e !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_after c=%0d got %h exp=%b run=%b want 0000 exp=0 run=0", c, nums_e, exp_e, run_e);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0;
        test_reset();
        test_countdown();
        test_restart();
        test_borrow();
        test_pause();
        test_clear();
        test_zero_start();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
